// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the N-channel stream multiplexer.
//   mux_mode_t : arbitration mode (fixed select or round-robin)
//   sel_w()    : channel-index width for a given channel count
package stream_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_t;

  // Width of a channel index. Clamped to 1 bit so a degenerate count
  // never yields a zero-width port.
  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_n_rr_arbiter.sv
// Combinational rotating-priority arbiter.
//   req     : per-channel request vector
//   ptr     : channel with highest priority this cycle (< N_CH)
//   gnt_idx : first requesting channel scanning ptr, ptr+1, ... mod N_CH
//   gnt_v   : any request present
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int SEL_W = sel_w(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_v
);

  int               idx;
  logic [SEL_W-1:0] idx_s;

  // Scan from the farthest offset down to offset 0 so the last hit written
  // is the one closest to ptr.
  always_comb begin
    gnt_idx = '0;
    gnt_v   = |req;
    idx     = 0;
    idx_s   = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      idx_s = SEL_W'(idx);
      if (req[idx_s]) gnt_idx = idx_s;
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// N-channel, W-bit stream multiplexer with a registered output stage.
//   clk, rst  : clock, synchronous active-high reset
//   mode      : 0 = forward channel sel, 1 = round-robin over valid channels
//   sel       : channel index used in fixed mode
//   in_valid  : per-channel valid
//   in_data   : channel i at bits [i*W +: W]
//   in_ready  : per-channel ready, one-hot or zero (combinational)
//   out_valid : output register holds a word
//   out_data  : registered word
//   out_ch    : channel the registered word came from
//   out_ready : consumer takes the word
module stream_mux_n
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int W     = 4,
  parameter int SEL_W = sel_w(N_CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic [N_CH-1:0]     in_valid,
  input  logic [N_CH*W-1:0]   in_data,
  output logic [N_CH-1:0]     in_ready,
  output logic                out_valid,
  output logic [W-1:0]        out_data,
  output logic [SEL_W-1:0]    out_ch,
  input  logic                out_ready
);

  mux_mode_t        mode_e;
  logic             can_load;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_g;
  logic             rr_v;
  logic             fix_v;
  logic [SEL_W-1:0] g;
  logic             gnt_v;
  logic             load;
  logic [W-1:0]     ch_data [N_CH];

  assign mode_e   = mux_mode_t'(mode);
  assign can_load = !out_valid || out_ready;

  rr_arbiter #(.N_CH(N_CH), .SEL_W(SEL_W)) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt_idx (rr_g),
    .gnt_v   (rr_v)
  );

  // sel can exceed N_CH-1 when N_CH is not a power of two; such a select
  // never grants, so the out-of-range index is never used.
  always_comb begin
    fix_v = 1'b0;
    if (int'(sel) < N_CH) fix_v = in_valid[sel];
  end

  always_comb begin
    g     = sel;
    gnt_v = fix_v;
    if (mode_e == MODE_RR) begin
      g     = rr_g;
      gnt_v = rr_v;
    end
  end

  assign load = can_load && gnt_v;

  // Unpack the flat data bus so the mux is a plain array index on g;
  // unselected channels cannot reach out_data.
  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    assign ch_data[i] = in_data[i*W +: W];
    assign in_ready[i] = !rst && load && (g == SEL_W'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else if (can_load) begin
      if (gnt_v) begin
        out_valid <= 1'b1;
        out_data  <= ch_data[g];
        out_ch    <= g;
        // Pointer only advances on round-robin grants, so fixed-mode
        // traffic leaves the rotation where it was.
        if (mode_e == MODE_RR)
          rr_ptr <= (int'(g) == N_CH - 1) ? '0 : g + 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
